arb_mux2_rtl: RTL and testbench

ARB_MUX2_RTL -- requirements
Module: arb_mux2_rtl

---
 rtl/arb_mux2_rtl_pkg.sv | 17 +
 rtl/arb_rr2.sv | 42 ++++
 rtl/arb_mux2_rtl.sv | 76 +++++++
 tb/tb_arb_mux2_rtl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/arb_mux2_rtl_pkg.sv
// Shared definitions for the two-input arbitrated message mux.
// Holds the default message width, the source-index type and a grant decoding helper.
package arb_mux2_rtl_pkg;

  localparam int unsigned NBITS_DEFAULT = 4;

  typedef logic src_t;

  localparam src_t SRC_IN0 = 1'b0;
  localparam src_t SRC_IN1 = 1'b1;

  // A one-hot grant maps to its source index through its upper bit.
  function automatic src_t grant_to_src(input logic [1:0] gnt);
    return gnt[1] ? SRC_IN1 : SRC_IN0;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin arbiter with a one-bit priority pointer.
// When the update enable is high and a grant is issued, priority moves to the other requester.
module arb_rr2
  import arb_mux2_rtl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  // Winning requester 0 hands priority to requester 1, and vice versa.
  always_comb begin
    prio_d = prio_q;
    if (en_i && (gnt_o != 2'b00)) begin
      prio_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/arb_mux2_rtl.sv
// Merges two valid/ready message streams into one through a registered one-entry buffer.
// Round-robin arbitration between the inputs; the buffer may drain and refill in the same cycle.
module arb_mux2_rtl
  import arb_mux2_rtl_pkg::*;
#(
  parameter int unsigned nbits = NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in0_val,
  output logic             in0_rdy,
  input  logic [nbits-1:0] in0_msg,
  input  logic             in1_val,
  output logic             in1_rdy,
  input  logic [nbits-1:0] in1_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [nbits-1:0] out_msg,
  output src_t             out_src
);

  logic             out_val_q, out_val_d;
  logic [nbits-1:0] out_msg_q, out_msg_d;
  src_t             out_src_q, out_src_d;

  logic             space;
  logic [1:0]       gnt;
  logic             xfer;
  logic [nbits-1:0] sel_msg;

  // Readiness is withheld while reset is high so nothing is accepted then.
  assign space = ~reset & (~out_val_q | out_rdy);

  arb_rr2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_i ({in1_val, in0_val}),
    .en_i  (space),
    .gnt_o (gnt)
  );

  assign in0_rdy = space & gnt[0];
  assign in1_rdy = space & gnt[1];
  assign xfer    = space & (gnt != 2'b00);
  assign sel_msg = gnt[1] ? in1_msg : in0_msg;

  always_comb begin
    out_val_d = out_val_q;
    out_msg_d = out_msg_q;
    out_src_d = out_src_q;
    if (xfer) begin
      out_val_d = 1'b1;
      out_msg_d = sel_msg;
      out_src_d = grant_to_src(gnt);
    end else if (out_rdy) begin
      out_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_val_q <= 1'b0;
      out_msg_q <= '0;
      out_src_q <= SRC_IN0;
    end else begin
      out_val_q <= out_val_d;
      out_msg_q <= out_msg_d;
      out_src_q <= out_src_d;
    end
  end

  assign out_val = out_val_q;
  assign out_msg = out_msg_q;
  assign out_src = out_src_q;

endmodule

// File: tb/tb_arb_mux2_rtl.sv
// Bench for arb_mux2_rtl: directed scenarios plus randomized traffic against a rule-level model
// and an in-order scoreboard of accepted messages.
module tb_arb_mux2_rtl;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in0_val, in1_val, out_rdy;
  logic [NB-1:0] in0_msg, in1_msg;
  logic          in0_rdy, in1_rdy, out_val, out_src;
  logic [NB-1:0] out_msg;

  int checks   = 0;
  int failures = 0;

  // Rule-level reference state
  logic          m_val, m_src, m_prio;
  logic [NB-1:0] m_msg;
  logic [NB:0]   sb[$];
  logic          l_rdy0, l_rdy1;
  logic [NB:0]   front;

  always #5 clk = ~clk;

  arb_mux2_rtl #(.nbits(NB)) dut (
    .clk     (clk),
    .reset   (reset),
    .in0_val (in0_val),
    .in0_rdy (in0_rdy),
    .in0_msg (in0_msg),
    .in1_val (in1_val),
    .in1_rdy (in1_rdy),
    .in1_msg (in1_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .out_src (out_src)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic v0, input logic [NB-1:0] m0,
                     input logic v1, input logic [NB-1:0] m1, input logic ordy);
    logic space_e, has_g, g, e0, e1;
    @(negedge clk);
    reset = r; in0_val = v0; in0_msg = m0; in1_val = v1; in1_msg = m1; out_rdy = ordy;
    #1;
    space_e = !r && (!m_val || ordy);
    has_g   = v0 || v1;
    g       = (v0 && v1) ? m_prio : v1;
    e0      = space_e && has_g && (g == 1'b0);
    e1      = space_e && has_g && (g == 1'b1);
    chk("in0_rdy", 32'(in0_rdy), 32'(e0));
    chk("in1_rdy", 32'(in1_rdy), 32'(e1));
    chk("rdy_exclusive", 32'(in0_rdy & in1_rdy), 32'd0);
    l_rdy0 = in0_rdy; l_rdy1 = in1_rdy;
    if (r) begin
      sb.delete();
    end else begin
      if (out_val && out_rdy) begin
        chk("sb_underflow", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          front = sb.pop_front();
          chk("sb_order", 32'({out_src, out_msg}), 32'(front));
        end
      end
      if (in0_val && in0_rdy) sb.push_back({1'b0, in0_msg});
      if (in1_val && in1_rdy) sb.push_back({1'b1, in1_msg});
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_val = 1'b0; m_msg = '0; m_src = 1'b0; m_prio = 1'b0;
    end else if (space_e && has_g) begin
      m_val = 1'b1; m_msg = g ? m1 : m0; m_src = g; m_prio = !g;
    end else if (ordy) begin
      m_val = 1'b0;
    end
    chk("out_val", 32'(out_val), 32'(m_val));
    chk("out_msg", 32'(out_msg), 32'(m_msg));
    chk("out_src", 32'(out_src), 32'(m_src));
  endtask

  initial begin
    m_val = 1'b0; m_msg = '0; m_src = 1'b0; m_prio = 1'b0;
    reset = 1'b1; in0_val = 1'b0; in1_val = 1'b0; in0_msg = '0; in1_msg = '0; out_rdy = 1'b0;

    // Reset state
    cyc(1, 1, 4'h9, 1, 4'h6, 1);
    chk("rst_rdy0", 32'(l_rdy0), 32'd0);
    chk("rst_rdy1", 32'(l_rdy1), 32'd0);
    cyc(1, 0, 4'h0, 0, 4'h0, 0);
    chk("rst_out_val", 32'(out_val), 32'd0);
    chk("rst_out_msg", 32'(out_msg), 32'd0);

    // First transfer right after reset
    cyc(0, 1, 4'h3, 0, 4'h0, 1);
    chk("first_rdy0", 32'(l_rdy0), 32'd1);
    chk("first_val", 32'(out_val), 32'd1);
    chk("first_msg", 32'(out_msg), 32'h3);
    chk("first_src", 32'(out_src), 32'd0);

    // Alternation with both inputs valid from prio=0
    cyc(1, 0, 4'h0, 0, 4'h0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 4'hA, 1, 4'h5, 1);
      chk("alt_msg", 32'(out_msg), (i % 2 == 0) ? 32'hA : 32'h5);
      chk("alt_src", 32'(out_src), 32'(i % 2));
    end

    // Stall with a full buffer, then drain and refill in one cycle
    cyc(0, 1, 4'h7, 0, 4'h0, 1);
    chk("stall_load", 32'(out_msg), 32'h7);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 4'h1, 1, 4'h2, 0);
      chk("stall_hold_msg", 32'(out_msg), 32'h7);
      chk("stall_hold_val", 32'(out_val), 32'd1);
      chk("stall_rdy_any", 32'(l_rdy0 | l_rdy1), 32'd0);
    end
    cyc(0, 1, 4'h1, 1, 4'h2, 1);
    chk("refill_msg", 32'(out_msg), 32'h2);
    chk("refill_src", 32'(out_src), 32'd1);

    // Lone in1 request wins while prio points at in0
    cyc(1, 0, 4'h0, 0, 4'h0, 1);
    cyc(0, 0, 4'h0, 1, 4'hC, 1);
    chk("lone1_rdy1", 32'(l_rdy1), 32'd1);
    chk("lone1_src", 32'(out_src), 32'd1);
    chk("lone1_msg", 32'(out_msg), 32'hC);
    cyc(0, 1, 4'h4, 1, 4'h8, 1);
    chk("lone1_prio_after", 32'(out_src), 32'd0);

    // Reset discards a stalled buffered message
    cyc(0, 0, 4'h0, 0, 4'h0, 1);
    cyc(0, 1, 4'hF, 0, 4'h0, 0);
    chk("pre_rst_msg", 32'(out_msg), 32'hF);
    cyc(1, 0, 4'h0, 0, 4'h0, 0);
    chk("mid_rst_val", 32'(out_val), 32'd0);
    chk("mid_rst_msg", 32'(out_msg), 32'd0);
    cyc(0, 0, 4'h0, 0, 4'h0, 1);
    chk("post_rst_val", 32'(out_val), 32'd0);
    cyc(0, 1, 4'h6, 1, 4'h9, 1);
    chk("post_rst_prio", 32'(out_src), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 1000; i++) begin
      cyc(($urandom_range(63) == 0), 1'($urandom), 4'($urandom), 1'($urandom),
          4'($urandom), ($urandom_range(3) != 0));
    end
    cyc(0, 0, 4'h0, 0, 4'h0, 1);
    cyc(0, 0, 4'h0, 0, 4'h0, 1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
